// File: rtl/crc_ahb_mc_host_if.sv
// AHB-Lite slave front end for NUM_CH CRC channels, 0x20 register window per channel.
// Define CRC_HIF_TIMEOUT_EN to turn long wait states into an ERROR response after TIMEOUT_CYC cycles.
module crc_ahb_mc_host_if #(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELx,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HADDR,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           bus_wr,
  output logic [1:0]            bus_size,
  input  logic [32*NUM_CH-1:0]  crc_out,
  input  logic [32*NUM_CH-1:0]  crc_init_out,
  input  logic [32*NUM_CH-1:0]  crc_poly_out,
  input  logic [8*NUM_CH-1:0]   crc_idr_out,
  input  logic [NUM_CH-1:0]     buffer_full,
  input  logic [NUM_CH-1:0]     read_wait,
  input  logic [NUM_CH-1:0]     reset_pending,
  output logic [NUM_CH-1:0]     buffer_write_en,
  output logic [NUM_CH-1:0]     buffer_read_en,
  output logic [NUM_CH-1:0]     crc_init_en,
  output logic [NUM_CH-1:0]     crc_idr_en,
  output logic [NUM_CH-1:0]     crc_poly_en,
  output logic [NUM_CH-1:0]     reset_chain,
  output logic [2*NUM_CH-1:0]   crc_poly_size,
  output logic [2*NUM_CH-1:0]   rev_in_type,
  output logic [NUM_CH-1:0]     rev_out_type
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] OFF_DR   = 3'd0;
  localparam logic [2:0] OFF_IDR  = 3'd1;
  localparam logic [2:0] OFF_CR   = 3'd2;
  localparam logic [2:0] OFF_INIT = 3'd4;
  localparam logic [2:0] OFF_POL  = 3'd5;

  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_hselx_pp;
  logic [1:0]        r_htrans_pp;
  logic              r_hwrite_pp;
  logic [2:0]        r_off_pp;
  logic [CH_W-1:0]   r_ch_pp;
  logic [1:0]        r_hsize_pp;
  logic [4:0]        r_cr [NUM_CH];

  logic              w_sample;
  logic              w_ah_xfer;
  logic [2:0]        w_ah_off;
  logic [CH_W-1:0]   w_ah_ch;
  logic              w_ah_off_ok;
  logic              w_ah_ch_ok;
  logic              w_ah_err;
  logic              w_dp_xfer;
  logic [NUM_CH-1:0] w_ch_oh;
  logic              w_is_dr;
  logic              w_is_idr;
  logic              w_is_cr;
  logic              w_is_init;
  logic              w_is_pol;
  logic              w_stall;
  logic              w_timeout;
  logic              w_done;
  logic              w_unused;

  assign w_unused = &{1'b0, HADDR[31:CH_W+5], HADDR[1:0], r_htrans_pp[0]};

  // Address-phase decode; an errored transfer is diverted to ERR1 and never reaches the data phase in OK.
  assign w_sample    = HREADY && HREADYOUT;
  assign w_ah_xfer   = HSELx && HTRANS[1];
  assign w_ah_off    = HADDR[4:2];
  assign w_ah_ch     = HADDR[CH_W+4:5];
  assign w_ah_off_ok = (w_ah_off == OFF_DR) || (w_ah_off == OFF_IDR) || (w_ah_off == OFF_CR) ||
                       (w_ah_off == OFF_INIT) || (w_ah_off == OFF_POL);
  assign w_ah_ch_ok  = (32'(w_ah_ch) < NUM_CH);
  assign w_ah_err    = w_ah_xfer && (!w_ah_off_ok || !w_ah_ch_ok || (HSIZE > 3'b010));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_hselx_pp  <= 1'b0;
      r_htrans_pp <= 2'b00;
      r_hwrite_pp <= 1'b0;
      r_off_pp    <= 3'd0;
      r_ch_pp     <= '0;
      r_hsize_pp  <= 2'b00;
    end else if (w_sample) begin
      r_hselx_pp  <= HSELx;
      r_htrans_pp <= HTRANS;
      r_hwrite_pp <= HWRITE;
      r_off_pp    <= w_ah_off;
      r_ch_pp     <= w_ah_ch;
      r_hsize_pp  <= HSIZE[1:0];
    end
  end

  assign w_dp_xfer = r_hselx_pp && r_htrans_pp[1];
  assign w_is_dr   = (r_off_pp == OFF_DR);
  assign w_is_idr  = (r_off_pp == OFF_IDR);
  assign w_is_cr   = (r_off_pp == OFF_CR);
  assign w_is_init = (r_off_pp == OFF_INIT);
  assign w_is_pol  = (r_off_pp == OFF_POL);

  always_comb begin
    w_ch_oh = '0;
    for (int n = 0; n < NUM_CH; n++) w_ch_oh[n] = (r_ch_pp == CH_W'(n));
  end

  assign w_stall = w_dp_xfer &&
                   (( r_hwrite_pp && w_is_dr   && |(buffer_full   & w_ch_oh)) ||
                    (!r_hwrite_pp && w_is_dr   && |(read_wait     & w_ch_oh)) ||
                    ( r_hwrite_pp && w_is_init && |(reset_pending & w_ch_oh)));

`ifdef CRC_HIF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;

  assign w_wait_nxt = r_wait_cnt + CNT_W'(1);
  assign w_timeout  = (w_wait_nxt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge HCLK) begin
    if (!HRESETn)                                r_wait_cnt <= '0;
    else if ((r_state == ST_OK) && !HREADYOUT)   r_wait_cnt <= w_wait_nxt;
    else                                         r_wait_cnt <= '0;
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC > 0);
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= ST_OK;
    else          r_state <= w_state_nxt;
  end

  // In OK, HREADYOUT=1 means the address phase is sampled iff HREADY is high.
  always_comb begin
    w_state_nxt = r_state;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_OK: begin
        if (w_stall) begin
          HREADYOUT = 1'b0;
          if (w_timeout) w_state_nxt = ST_ERR1;
        end else begin
          w_done = w_dp_xfer;
          if (HREADY && w_ah_err) w_state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP       = 1'b1;
        w_state_nxt = (HREADY && w_ah_err) ? ST_ERR1 : ST_OK;
      end
      default: w_state_nxt = ST_OK;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int n = 0; n < NUM_CH; n++) r_cr[n] <= 5'd0;
    end else begin
      for (int n = 0; n < NUM_CH; n++)
        if (w_done && w_ch_oh[n] && r_hwrite_pp && w_is_cr) r_cr[n] <= HWDATA[7:3];
    end
  end

  assign bus_wr   = HWDATA;
  assign bus_size = r_hsize_pp;

  always_comb begin
    buffer_write_en = '0;
    buffer_read_en  = '0;
    crc_init_en     = '0;
    crc_idr_en      = '0;
    crc_poly_en     = '0;
    reset_chain     = '0;
    crc_poly_size   = '0;
    rev_in_type     = '0;
    rev_out_type    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      crc_poly_size[2*n +: 2] = r_cr[n][1:0];
      rev_in_type[2*n +: 2]   = r_cr[n][3:2];
      rev_out_type[n]         = r_cr[n][4];
      if (w_done && w_ch_oh[n]) begin
        buffer_write_en[n] =  r_hwrite_pp && w_is_dr;
        buffer_read_en[n]  = !r_hwrite_pp && w_is_dr;
        crc_init_en[n]     =  r_hwrite_pp && w_is_init;
        crc_idr_en[n]      =  r_hwrite_pp && w_is_idr;
        crc_poly_en[n]     =  r_hwrite_pp && w_is_pol;
        reset_chain[n]     =  r_hwrite_pp && w_is_cr && HWDATA[0];
      end
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (w_done && !r_hwrite_pp) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_ch_oh[n]) begin
          case (r_off_pp)
            OFF_DR:   HRDATA = crc_out[32*n +: 32];
            OFF_IDR:  HRDATA = {24'h0, crc_idr_out[8*n +: 8]};
            OFF_CR:   HRDATA = {24'h0, r_cr[n], 3'b000};
            OFF_INIT: HRDATA = crc_init_out[32*n +: 32];
            OFF_POL:  HRDATA = crc_poly_out[32*n +: 32];
            default:  HRDATA = 32'h0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_ahb_mc_host_if.sv
// Directed bench for crc_ahb_mc_host_if: 4 channels, single master with HREADY looped from HREADYOUT.
module tb_crc_ahb_mc_host_if;

  logic         clk = 1'b0;
  logic         rstn;
  logic         hsel, hwrite, hready;
  logic [31:0]  haddr;
  logic [2:0]   hsize;
  logic [1:0]   htrans;
  logic [31:0]  hwdata;
  logic [31:0]  hrdata;
  logic         hreadyout, hresp;
  logic [31:0]  bus_wr;
  logic [1:0]   bus_size;
  logic [127:0] crc_out, crc_init_out, crc_poly_out;
  logic [31:0]  crc_idr_out;
  logic [3:0]   buffer_full, read_wait, reset_pending;
  logic [3:0]   bwe, bre, init_en, idr_en, poly_en, rst_chain;
  logic [7:0]   poly_size, rev_in;
  logic [3:0]   rev_out;

  int n_cmp = 0;
  int n_err = 0;

  assign hready = hreadyout;

  crc_ahb_mc_host_if dut (
    .HCLK(clk), .HRESETn(rstn), .HSELx(hsel), .HWRITE(hwrite), .HREADY(hready),
    .HADDR(haddr), .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .bus_wr(bus_wr), .bus_size(bus_size),
    .crc_out(crc_out), .crc_init_out(crc_init_out), .crc_poly_out(crc_poly_out),
    .crc_idr_out(crc_idr_out), .buffer_full(buffer_full), .read_wait(read_wait),
    .reset_pending(reset_pending), .buffer_write_en(bwe), .buffer_read_en(bre),
    .crc_init_en(init_en), .crc_idr_en(idr_en), .crc_poly_en(poly_en),
    .reset_chain(rst_chain), .crc_poly_size(poly_size), .rev_in_type(rev_in),
    .rev_out_type(rev_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic addr(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a);
    hsel   = sel;
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = 3'b010;
  endtask

  function automatic logic [31:0] all_strobes();
    return {8'h0, bwe, bre, init_en, idr_en, poly_en, rst_chain};
  endfunction

  initial begin
    rstn          = 1'b0;
    hwdata        = 32'h0;
    crc_out       = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    crc_init_out  = {32'h13000003, 32'h12000002, 32'h11000001, 32'h10000000};
    crc_poly_out  = {32'h04C11DB7, 32'h1EDC6F41, 32'h00001021, 32'h00008005};
    crc_idr_out   = 32'h44332211;
    buffer_full   = 4'b0;
    read_wait     = 4'b0;
    reset_pending = 4'b0;
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    repeat (3) cyc();
    chk("rst_ready_resp", {hresp, hreadyout}, 32'h1);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_strobes", all_strobes(), 32'h0);
    rstn = 1'b1;

    // CR read ch0 after reset
    addr(1'b1, 2'b10, 1'b0, 32'h08);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    chk("cr0_rd_ready_resp", {hresp, hreadyout}, 32'h1);
    chk("cr0_rd_data", hrdata, 32'h0);

    // CR write ch1 with reset bit
    addr(1'b1, 2'b10, 1'b1, 32'h28);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    hwdata = 32'h000000F9;
    #1;
    chk("cr1_wr_reset_chain", {28'h0, rst_chain}, 32'h2);
    chk("cr1_wr_ready", {31'h0, hreadyout}, 32'h1);
    cyc();
    hwdata = 32'h0;
    #1;
    chk("cr1_reset_chain_done", {28'h0, rst_chain}, 32'h0);
    chk("cr1_fields", {16'h0, poly_size, rev_in}, 32'h0C0C);
    chk("cr1_rev_out", {28'h0, rev_out}, 32'h2);
    addr(1'b1, 2'b10, 1'b0, 32'h28);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    chk("cr1_readback", hrdata, 32'hF8);

    // DR write ch2 stalled three cycles by buffer_full
    addr(1'b1, 2'b10, 1'b1, 32'h40);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    hwdata = 32'hCAFE0001;
    buffer_full = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) cyc();
      #1;
      chk($sformatf("dr2_wait%0d", i), {bwe, 3'b0, hreadyout}, 32'h0);
    end
    cyc();
    buffer_full = 4'b0;
    #1;
    chk("dr2_release_ready", {31'h0, hreadyout}, 32'h1);
    chk("dr2_bwe", {28'h0, bwe}, 32'h4);
    chk("dr2_bus_wr", bus_wr, 32'hCAFE0001);
    chk("dr2_bus_size", {30'h0, bus_size}, 32'h2);
    cyc();
    #1;
    chk("dr2_bwe_single", {28'h0, bwe}, 32'h0);

    // Unmapped offset then a read of IDR ch0
    addr(1'b1, 2'b10, 1'b1, 32'h0C);
    cyc();
    addr(1'b1, 2'b10, 1'b0, 32'h04);
    hwdata = 32'h12345678;
    #1;
    chk("err1_ready_resp", {hresp, hreadyout}, 32'h2);
    chk("err1_strobes", all_strobes(), 32'h0);
    cyc();
    #1;
    chk("err2_ready_resp", {hresp, hreadyout}, 32'h3);
    chk("err2_strobes", all_strobes(), 32'h0);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    chk("idr0_ready_resp", {hresp, hreadyout}, 32'h1);
    chk("idr0_data", hrdata, 32'h11);

    // Oversized transfer to DR ch0
    addr(1'b1, 2'b10, 1'b0, 32'h00);
    hsize = 3'b011;
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    chk("size_err_resp", {bre, 2'b0, hresp, hreadyout}, 32'h2);
    cyc();
    cyc();
    #1;
    chk("size_err_recover", {hresp, hreadyout}, 32'h1);

    // NONSEQ then SEQ INIT writes, back to back
    addr(1'b1, 2'b10, 1'b1, 32'h10);
    cyc();
    addr(1'b1, 2'b11, 1'b1, 32'h70);
    hwdata = 32'h11111111;
    #1;
    chk("init_seq0", {init_en, 3'b0, hreadyout}, 32'h11);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    hwdata = 32'h22222222;
    #1;
    chk("init_seq1", {init_en, 3'b0, hreadyout}, 32'h81);
    cyc();
    #1;
    chk("init_seq_done", {28'h0, init_en}, 32'h0);

    // Pipelined reads DR ch3 then POL ch2
    addr(1'b1, 2'b10, 1'b0, 32'h60);
    cyc();
    addr(1'b1, 2'b10, 1'b0, 32'h54);
    #1;
    chk("dr3_read", hrdata, 32'hD3D3D3D3);
    chk("dr3_bre", {28'h0, bre}, 32'h8);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    chk("pol2_read", hrdata, 32'h1EDC6F41);

    // DR read ch0 with read_wait held 20 cycles
    addr(1'b1, 2'b10, 1'b0, 32'h00);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    read_wait = 4'b0001;
`ifdef CRC_HIF_TIMEOUT_EN
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) cyc();
      #1;
      if (i <= 16)
        chk($sformatf("rw_wait%0d", i), {bre, 2'b0, hresp, hreadyout}, 32'h0);
      else if (i == 17)
        chk("rw_timeout_err1", {bre, 2'b0, hresp, hreadyout}, 32'h2);
      else if (i == 18)
        chk("rw_timeout_err2", {bre, 2'b0, hresp, hreadyout}, 32'h3);
      else
        chk($sformatf("rw_idle%0d", i), {bre, 2'b0, hresp, hreadyout}, 32'h1);
    end
    cyc();
    read_wait = 4'b0;
    #1;
    chk("rw_after", {bre, 2'b0, hresp, hreadyout}, 32'h1);
`else
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) cyc();
      #1;
      chk($sformatf("rw_wait%0d", i), {bre, 2'b0, hresp, hreadyout}, 32'h0);
    end
    cyc();
    read_wait = 4'b0;
    #1;
    chk("rw_done", {bre, 2'b0, hresp, hreadyout}, 32'h11);
    chk("rw_data", hrdata, 32'hA0A0A0A0);
`endif

    // Reset in the middle of an error response
    cyc();
    addr(1'b1, 2'b10, 1'b0, 32'h18);
    cyc();
    addr(1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    chk("mid_err_err1", {hresp, hreadyout}, 32'h2);
    rstn = 1'b0;
    cyc();
    #1;
    chk("mid_err_reset", {hresp, hreadyout}, 32'h1);
    chk("mid_err_cr_clear", {rev_out, poly_size, rev_in}, 32'h0);
    rstn = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
